// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - MEM-stage load/store initiator driving the data memory port
//
// Purpose: accepts one load/store request per handshake, range-checks it,
// issues aligned memory operations (splitting naturally-misaligned accesses
// into two word loads or a run of byte stores), extends load data and returns
// exactly one response per request.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_size,        store flag, size (0 byte, 1 half, 2/3 word),
//   req_unsigned             zero-extend loads
//   req_addr, req_wdata      byte address, LSB-aligned store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata               load result (0 for stores and errors)
//   resp_err, resp_misalign  out-of-range / misaligned-trap flags
//   mem_stall                1 = no memory access this cycle
//   mem_op_code, mem_rwaddr, mem_wdata, mem_rdata   memory port
//
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned requests
// instead of splitting them.

module lsu_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_misalign,
    output logic              mem_stall,
    output logic [2:0]        mem_op_code,
    output logic [ADDR_W-1:0] mem_rwaddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("lsu_ctrl: DATA_W must be 32");
        end
    endgenerate

    // Memory operation encoding; stores mirror loads at +3
    localparam logic [2:0] OP_LB = 3'd0;
    localparam logic [2:0] OP_LW = 3'd2;
    localparam logic [2:0] OP_SB = 3'd3;

    typedef enum logic [1:0] {
        S_IDLE,
`ifndef LSU_MISALIGN_TRAP_EN
        S_LD2,
        S_ST,
`endif
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [1:0]  size_q, size_d;
    logic        err_q, err_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`else
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] word0_q, word0_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              split_q, split_d;
    logic [63:0]       cat_shift;
    logic [1:0]        cnt_last;
`endif

    logic [1:0]  sz;
    logic [1:0]  nb_m1;
    logic [32:0] last_addr;
    logic        range_err;
    logic        mis_req;
    logic        accept;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ext;

    // Request decode: size 3 behaves as word
    always_comb begin
        sz        = (req_size == 2'd3) ? 2'd2 : req_size;
        nb_m1     = (sz == 2'd0) ? 2'd0 : ((sz == 2'd1) ? 2'd1 : 2'd3);
        last_addr = {1'b0, req_addr} + {31'b0, nb_m1};
        range_err = |last_addr[32:ADDR_W];
        mis_req   = ((sz == 2'd1) && req_addr[0]) || ((sz == 2'd2) && (req_addr[1:0] != 2'b00));
    end

    // Reset gates acceptance so an asserted reset never issues an access
    assign req_ready = ((state_q == S_IDLE) || (state_q == S_RESP)) && !rst;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`else
            addr_q  <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            cnt_q   <= 2'd0;
            split_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`else
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            word0_q <= word0_d;
            cnt_q   <= cnt_d;
            split_q <= split_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        err_d       = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d       = mis_q;
`else
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word0_d     = word0_q;
        cnt_d       = cnt_q;
        split_d     = split_q;
        cnt_last    = (size_q == 2'd1) ? 2'd1 : 2'd3;
`endif
        mem_stall   = 1'b1;
        mem_op_code = OP_LW;
        mem_rwaddr  = '0;
        mem_wdata   = '0;

        case (state_q)
`ifndef LSU_MISALIGN_TRAP_EN
            S_LD2: begin
                // First word arrives now; fetch the following word
                mem_stall   = 1'b0;
                mem_op_code = OP_LW;
                mem_rwaddr  = {addr_q[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
                word0_d     = mem_rdata;
                state_d     = S_RESP;
            end
            S_ST: begin
                mem_stall   = 1'b0;
                mem_op_code = OP_SB;
                mem_rwaddr  = addr_q + {{(ADDR_W-2){1'b0}}, cnt_q};
                mem_wdata   = {24'b0, wdata_q[8*cnt_q +: 8]};
                if (cnt_q == cnt_last) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
`endif
            S_RESP:  state_d = S_IDLE;
            default: ;
        endcase

        if (accept) begin
            state_d = S_RESP;
            we_d    = req_we;
            uns_d   = req_unsigned;
            size_d  = sz;
            err_d   = range_err;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_d   = !range_err && mis_req;
            if (!range_err && !mis_req) begin
                mem_stall   = 1'b0;
                mem_op_code = (req_we ? OP_SB : OP_LB) + {1'b0, sz};
                mem_rwaddr  = req_addr[ADDR_W-1:0];
                mem_wdata   = req_wdata;
            end
`else
            addr_d  = req_addr[ADDR_W-1:0];
            wdata_d = req_wdata;
            cnt_d   = 2'd1;
            split_d = 1'b0;
            if (range_err) begin
                // no access; error response next cycle
            end else if (!mis_req) begin
                mem_stall   = 1'b0;
                mem_op_code = (req_we ? OP_SB : OP_LB) + {1'b0, sz};
                mem_rwaddr  = req_addr[ADDR_W-1:0];
                mem_wdata   = req_wdata;
            end else if (!req_we) begin
                mem_stall   = 1'b0;
                mem_op_code = OP_LW;
                mem_rwaddr  = {req_addr[ADDR_W-1:2], 2'b00};
                split_d     = 1'b1;
                state_d     = S_LD2;
            end else begin
                // Byte 0 goes out now, the rest from S_ST
                mem_stall   = 1'b0;
                mem_op_code = OP_SB;
                mem_rwaddr  = req_addr[ADDR_W-1:0];
                mem_wdata   = {24'b0, req_wdata[7:0]};
                state_d     = S_ST;
            end
`endif
        end
    end

    // Response path: aligned loads take memory data directly (already
    // sign-extended by memory); split loads stitch two words together.
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        raw = mem_rdata;
`else
        cat_shift = {mem_rdata, word0_q} >> {addr_q[1:0], 3'b000};
        raw       = split_q ? cat_shift[31:0] : mem_rdata;
`endif
        case (size_q)
            2'd0:    ext = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'd1:    ext = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_valid && err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_misalign = resp_valid && mis_q;
    assign resp_rdata    = (resp_valid && !we_q && !err_q && !mis_q) ? ext : '0;
`else
    assign resp_misalign = 1'b0;
    assign resp_rdata    = (resp_valid && !we_q && !err_q) ? ext : '0;
`endif

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store initiator in the MEM stage; the requester side of the data `memory` port (`op_code`, `rwaddr`, `wdata`, `rdata`, `stall`).
- Accepts one pipeline request per handshake and issues the accesses.
- Splits naturally-misaligned accesses into aligned memory operations.
- Zero-extends unsigned loads, range-checks addresses, returns one response per request.

Parameters:
- ADDR_W, 11, memory byte-address width; valid range is 0 .. 2^ADDR_W-1 (0x000-0x7FF).
- DATA_W, 32, data width; fixed at 32, with the value check elaborated.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid&req_ready
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- req_unsigned  in  1  zero-extend load (LBU/LHU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  out-of-range access
- resp_misalign  out  1  misaligned trap (see Optional Feature)
- mem_stall  out  1  1 = no access this cycle (memory cen high)
- mem_op_code  out  3  mem.vh encoding (`LoadByte.. `StoreWord)
- mem_rwaddr  out  11  byte address to memory
- mem_wdata  out  32  store data to memory
- mem_rdata  in  32  memory read data, valid the cycle after issue

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, resp_misalign=0.
  - mem_stall=1, mem_op_code=`LoadWord, mem_rwaddr=0, mem_wdata=0.
- Handshake:
  - req_ready=1 in IDLE and RESP, 0 otherwise.
  - Accepting in RESP gives back-to-back aligned throughput of 1/cycle.
- First-access timing: memory outputs are combinational from the request in the accept cycle N. The memory samples at the N edge, so mem_rdata is valid in N+1 only.
- Range error: if addr + bytes - 1 > 0x7FF (any upper bit set), no memory access is made. resp_valid=1, resp_err=1, resp_rdata=0 in N+1.
- Alignment: misaligned = addr not a multiple of the access size.
- Aligned access:
  - One access at N with the matching `LoadX/`StoreX, rwaddr=addr[10:0], wdata=req_wdata.
  - resp_valid at N+1.
  - Loads: resp_rdata=mem_rdata; if req_unsigned, mask to 8/16 bits, since memory sign-extends.
- Misaligned load (states IDLE->LD2->RESP):
  - N: `LoadWord at addr&~3.
  - N+1: register word0; issue `LoadWord at (addr&~3)+4.
  - N+2: resp_valid; extract ({mem_rdata,word0} >> 8*addr[1:0]) to size, then sign/zero extend.
  - Two accesses are always issued, even if the access does not cross a word.
- Misaligned store (IDLE->ST->RESP):
  - Byte counter k=0..bytes-1; one `StoreByte per cycle, rwaddr=addr+k, wdata[7:0]=req_wdata byte k.
  - Half: cycles N,N+1, resp at N+2. Word: N..N+3, resp at N+4.
- Request capture: all request fields are registered at acceptance; req_* is ignored while busy.
- Bank crossing (0x3FF->0x400) needs no special handling.
- Idle drive: mem_stall=1 whenever no access is issued.
- Reset mid-operation: abort immediately to the reset values; partial byte stores stay written; no resp_valid.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - Misaligned requests are not split and no memory access is made.
  - resp_valid=1, resp_misalign=1, resp_rdata=0 in N+1.
  - LD2/ST states and the byte counter are not built.
- When undefined: splitting as above; resp_misalign tied 0.

Test Plan:
- Aligned LW addr 0x008, mem=0x8899AABB:
  - N: mem_stall=0, `LoadWord, rwaddr 0x008.
  - N+1: resp_valid=1, rdata 0x8899AABB.
- Word 0x400=0x0000F200: LB 0x401 -> 0xFFFFFFF2; LBU 0x401 -> 0x000000F2; back-to-back requests with req_ready=1 in RESP.
- Misaligned LW 0x3FE, mem 0x3FC=0x11223344, 0x400=0x55667788:
  - Accesses at 0x3FC then 0x400.
  - N+2: rdata 0x77881122.
  - With macro: resp_misalign=1 at N+1, no access.
- Misaligned SW 0x005 data 0xDEADBEEF:
  - `StoreByte at 5,6,7,8 with data EF,BE,AD,DE; resp at N+4.
  - LW 0x004 then shows bytes [15:8]=EF, [23:16]=BE, [31:24]=AD.
- LW 0x7FE and SB 0x1000: no access (mem_stall=1); N+1 resp_err=1, rdata 0.
- rst asserted after second byte of a misaligned SW: outputs immediately at reset values, no resp_valid; next request proceeds normally.
